cmos_capture_win: RTL

CMOS_CAPTURE_WIN -- requirements
Module: cmos_capture_win

---
 rtl/cmos_cap_pkg.sv | 16 +
 rtl/cmos_byte_pack.sv | 53 +++++
 rtl/cmos_capture_win.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cmos_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module : cmos_cap_pkg
// Brief  : Shared mode encodings and default sizing for the CMOS capture path.
// Rev    : 1.0
// ============================================================================
package cmos_cap_pkg;

  localparam logic MODE_RGB565     = 1'b0;
  localparam logic MODE_RAW8       = 1'b1;

  localparam int   DEF_CNT_W       = 13;
  localparam int   DEF_FRAME_WAIT  = 10;

endpackage : cmos_cap_pkg
`default_nettype wire

// File: rtl/cmos_byte_pack.sv
`default_nettype none
// ============================================================================
// Module : cmos_byte_pack
// Brief  : Pairs RGB565 bytes into 16-bit pixels or passes RAW8 bytes through.
// Rev    : 1.0
// ============================================================================
module cmos_byte_pack
  import cmos_cap_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        href,
  input  logic [7:0]  data,
  input  logic        mode,
  output logic        pix_stb,
  output logic [15:0] pix_word
);

  logic       r_toggle;
  logic [7:0] r_first;

  // Strobe is combinational so the pixel leaves in the same cycle its last byte sits in S1.
  always_comb begin
    pix_stb  = 1'b0;
    pix_word = 16'h0000;
    if (href) begin
      if (mode == MODE_RAW8) begin
        pix_stb  = 1'b1;
        pix_word = {8'h00, data};
      end else if (r_toggle) begin
        pix_stb  = 1'b1;
        pix_word = {r_first, data};
      end
    end
  end

  // Dropping href clears the toggle, so an unpaired trailing byte is simply forgotten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_toggle <= 1'b0;
      r_first  <= 8'h00;
    end else if (!href || (mode == MODE_RAW8)) begin
      r_toggle <= 1'b0;
    end else begin
      r_toggle <= ~r_toggle;
      if (!r_toggle) begin
        r_first <= data;
      end
    end
  end

endmodule : cmos_byte_pack
`default_nettype wire

// File: rtl/cmos_capture_win.sv
`default_nettype none
// ============================================================================
// Module : cmos_capture_win
// Brief  : CMOS sensor capture with start-up frame skip, decimation and crop.
// Rev    : 1.0
// ============================================================================
module cmos_capture_win
  import cmos_cap_pkg::*;
#(
  parameter int FRAME_WAIT = DEF_FRAME_WAIT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             cam_pclk,
  input  logic             rst_n,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [7:0]       cam_data,
  input  logic             capture_en,
  input  logic             mode,
  input  logic [CNT_W-1:0] win_x,
  input  logic [CNT_W-1:0] win_y,
  input  logic [CNT_W-1:0] win_w,
  input  logic [CNT_W-1:0] win_h,
  input  logic [3:0]       skip,
  output logic             frame_vsync,
  output logic             frame_href,
  output logic             pix_valid,
  output logic [15:0]      pix_data,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_done
);

  localparam int                WAIT_W   = (FRAME_WAIT < 1) ? 1 : $clog2(FRAME_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(FRAME_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic             r_s1_vsync;
  logic             r_s1_href;
  logic [7:0]       r_s1_data;
  logic             r_s1_vsync_d;
  logic             r_s1_href_d;

  logic [WAIT_W-1:0] r_wait_cnt;
  logic [3:0]        r_phase;
  logic              r_sel;
  logic              w_sel_next;

  logic             r_mode;
  logic [CNT_W-1:0] r_win_x;
  logic [CNT_W-1:0] r_win_y;
  logic [CNT_W-1:0] r_win_w;
  logic [CNT_W-1:0] r_win_h;

  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;

  logic             w_fs;
  logic             w_line_end;
  logic             w_pack_stb;
  logic [15:0]      w_pack_word;
  logic             w_in_x;
  logic             w_in_y;
  logic             w_pix_fire;
  logic [CNT_W:0]   w_x_hi;
  logic [CNT_W:0]   w_y_hi;

  // Input stage: nothing below looks at the raw sensor pins.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vsync   <= 1'b0;
      r_s1_href    <= 1'b0;
      r_s1_data    <= 8'h00;
      r_s1_vsync_d <= 1'b0;
      r_s1_href_d  <= 1'b0;
    end else begin
      r_s1_vsync   <= cam_vsync;
      r_s1_href    <= cam_href;
      r_s1_data    <= cam_data;
      r_s1_vsync_d <= r_s1_vsync;
      r_s1_href_d  <= r_s1_href;
    end
  end

  assign w_fs       = r_s1_vsync & ~r_s1_vsync_d;
  assign w_line_end = ~r_s1_href & r_s1_href_d;

  cmos_byte_pack u_byte_pack (
    .clk      (cam_pclk),
    .rst_n    (rst_n),
    .href     (r_s1_href),
    .data     (r_s1_data),
    .mode     (r_mode),
    .pix_stb  (w_pack_stb),
    .pix_word (w_pack_word)
  );

  // Selection takes effect in the FS cycle itself so frame_vsync lines up with S1 vsync.
  always_comb begin
    w_sel_next = r_sel;
    if (!capture_en) begin
      w_sel_next = 1'b0;
    end else if (w_fs) begin
      w_sel_next = (r_wait_cnt == WAIT_MAX) && (r_phase == 4'd0);
    end
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_phase    <= 4'd0;
      r_sel      <= 1'b0;
    end else begin
      r_sel <= w_sel_next;
      if (!capture_en) begin
        r_wait_cnt <= '0;
        r_phase    <= 4'd0;
      end else if (w_fs) begin
        if (r_wait_cnt != WAIT_MAX) begin
          r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end else begin
          r_phase <= (r_phase >= skip) ? 4'd0 : r_phase + 4'd1;
        end
      end
    end
  end

  // Frame configuration is sampled only at frame start.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= MODE_RGB565;
      r_win_x <= '0;
      r_win_y <= '0;
      r_win_w <= '0;
      r_win_h <= '0;
    end else if (w_fs) begin
      r_mode  <= mode;
      r_win_x <= win_x;
      r_win_y <= win_y;
      r_win_w <= win_w;
      r_win_h <= win_h;
    end
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_fs) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_line_end) begin
      r_col <= '0;
      if (r_row != CNT_MAX) begin
        r_row <= r_row + CNT_W'(1);
      end
    end else if (w_pack_stb && (r_col != CNT_MAX)) begin
      r_col <= r_col + CNT_W'(1);
    end
  end

  // One extra bit keeps origin+size from wrapping near the top of the range.
  assign w_x_hi = {1'b0, r_win_x} + {1'b0, r_win_w};
  assign w_y_hi = {1'b0, r_win_y} + {1'b0, r_win_h};
  assign w_in_x = ({1'b0, r_col} >= {1'b0, r_win_x}) && ({1'b0, r_col} < w_x_hi);
  assign w_in_y = ({1'b0, r_row} >= {1'b0, r_win_y}) && ({1'b0, r_row} < w_y_hi);

  assign w_pix_fire = w_pack_stb & ~w_fs & r_sel & w_in_x & w_in_y;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_vsync <= 1'b0;
      frame_href  <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= 16'h0000;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_done  <= 1'b0;
    end else if (!capture_en) begin
      frame_vsync <= 1'b0;
      frame_href  <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= 16'h0000;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_vsync <= r_s1_vsync & w_sel_next;
      frame_href  <= r_s1_href & w_sel_next & w_in_y;
      pix_valid   <= w_pix_fire;
      pix_data    <= w_pix_fire ? w_pack_word : 16'h0000;
      pix_x       <= w_pix_fire ? (r_col - r_win_x) : '0;
      pix_y       <= w_pix_fire ? (r_row - r_win_y) : '0;
      frame_done  <= w_fs & r_sel;
    end
  end

endmodule : cmos_capture_win
`default_nettype wire
